// File: rtl/chip8_pkg.sv
// Shared types and constants for the Chip8 memory subsystem.
//   arb_state_t : arbiter pause FSM states (RUN, DRAIN, PAUSED)
//   owner_t     : memory transaction owner tag
//   CHIP8_MEM_ADDR_W : byte address width of the 4 KiB memory
package chip8_pkg;

  localparam int unsigned CHIP8_MEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_HOST  = 2'd1,
    OWN_FETCH = 2'd2,
    OWN_DATA  = 2'd3
  } owner_t;

endpackage

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter
// Shares the Chip8 dual-port byte memory among the host, CPU instruction
// fetch and CPU data access. One transaction per cycle, combinational grant,
// read data routed to the owner one cycle after the grant.
// Ports:
//   clk, reset (async, active low)
//   host_*  : host read/write requester (highest priority)
//   fetch_* : 16-bit instruction fetch, reads mem[a] and mem[a+1]
//   data_*  : CPU byte read/write requester
//   pause_req / pause_ack : host pause/drain handshake
//   mem_*   : dual-port memory interface (1-cycle registered read)
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W = CHIP8_MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [15:0]       fetch_instr,

  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [7:0]        data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [7:0]        data_rdata,

  input  logic              pause_req,
  output logic              pause_ack,

  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [7:0]        mem_wdata1,
  output logic [7:0]        mem_wdata2,
  output logic              mem_we1,
  output logic              mem_we2,
  input  logic [7:0]        mem_rdata1,
  input  logic [7:0]        mem_rdata2
);

  arb_state_t state, state_nxt;
  owner_t     last_cpu;   // OWN_FETCH or OWN_DATA: CPU requester served last
  owner_t     tag_owner;
  logic       tag_valid;

  owner_t     gnt_owner;
  logic       rd_gnt;
  logic       cpu_rd_gnt;

  // Grant selection. Grants are gated by reset so every output is 0 while
  // reset is held, even with requests pending.
  always_comb begin
    gnt_owner = OWN_NONE;
    if (reset) begin
      if (host_req) begin
        gnt_owner = OWN_HOST;
      end else if (state == RUN) begin
        if (fetch_req && data_req) begin
          gnt_owner = (last_cpu == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
        end else if (fetch_req) begin
          gnt_owner = OWN_FETCH;
        end else if (data_req) begin
          gnt_owner = OWN_DATA;
        end
      end
    end
  end

  assign host_gnt  = (gnt_owner == OWN_HOST);
  assign fetch_gnt = (gnt_owner == OWN_FETCH);
  assign data_gnt  = (gnt_owner == OWN_DATA);

  assign rd_gnt     = (host_gnt && !host_we) || fetch_gnt || (data_gnt && !data_we);
  assign cpu_rd_gnt = fetch_gnt || (data_gnt && !data_we);

  // Memory port steering
  always_comb begin
    mem_addr1  = '0;
    mem_addr2  = '0;
    mem_wdata1 = '0;
    mem_we1    = 1'b0;
    unique case (gnt_owner)
      OWN_HOST: begin
        mem_addr1  = host_addr;
        mem_wdata1 = host_wdata;
        mem_we1    = host_we;
      end
      OWN_DATA: begin
        mem_addr1  = data_addr;
        mem_wdata1 = data_wdata;
        mem_we1    = data_we;
      end
      OWN_FETCH: begin
        mem_addr1 = fetch_addr;
        mem_addr2 = fetch_addr + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign mem_we2    = 1'b0;
  assign mem_wdata2 = '0;

  // Pause FSM. From RUN or DRAIN the next state is PAUSED as soon as no CPU
  // read is being granted this cycle: any response then still pending is
  // delivered during the cycle the FSM spends in DRAIN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (pause_req) state_nxt = cpu_rd_gnt ? DRAIN : PAUSED;
      DRAIN:   if (!pause_req) state_nxt = RUN;
               else if (!cpu_rd_gnt) state_nxt = PAUSED;
      PAUSED:  if (!pause_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      last_cpu  <= OWN_FETCH;
      tag_owner <= OWN_NONE;
      tag_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      tag_valid <= rd_gnt;
      tag_owner <= rd_gnt ? gnt_owner : OWN_NONE;
      if (fetch_gnt || data_gnt) begin
        last_cpu <= gnt_owner;
      end
    end
  end

  // Response routing
  assign host_rvalid = tag_valid && (tag_owner == OWN_HOST);
  assign fetch_valid = tag_valid && (tag_owner == OWN_FETCH);
  assign data_rvalid = tag_valid && (tag_owner == OWN_DATA);

  assign host_rdata  = host_rvalid ? mem_rdata1 : '0;
  assign data_rdata  = data_rvalid ? mem_rdata1 : '0;
  assign fetch_instr = fetch_valid ? {mem_rdata1, mem_rdata2} : '0;

  assign pause_ack = (state == PAUSED);

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Self-checking bench for chip8_mem_arbiter with a behavioural dual-port
// memory (1-cycle registered read) and a response scoreboard.
module tb_chip8_mem_arbiter;

  localparam int AW = 12;
  localparam int O_HOST  = 1;
  localparam int O_FETCH = 2;
  localparam int O_DATA  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_gnt, host_rvalid;
  logic [7:0]    host_rdata;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_valid;
  logic [15:0]   fetch_instr;
  logic          data_req, data_we;
  logic [AW-1:0] data_addr;
  logic [7:0]    data_wdata;
  logic          data_gnt, data_rvalid;
  logic [7:0]    data_rdata;
  logic          pause_req, pause_ack;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [7:0]    mem_wdata1, mem_wdata2;
  logic          mem_we1, mem_we2;
  logic [7:0]    mem_rdata1, mem_rdata2;

  logic [7:0] mem [0:4095];

  typedef struct {
    int          owner;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2),
    .mem_we1(mem_we1), .mem_we2(mem_we2),
    .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2)
  );

  // Behavioural memory: read-before-write, registered read data.
  always @(posedge clk) begin
    if (mem_we1) mem[mem_addr1] <= mem_wdata1;
    mem_rdata1 <= mem[mem_addr1];
    mem_rdata2 <= mem[mem_addr2];
  end

  // Scoreboard monitor: every response pulse pops and checks one expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int nv;
      nv = int'(host_rvalid) + int'(fetch_valid) + int'(data_rvalid);
      if (nv > 1) begin
        n_checks++;
        n_fail++;
        $display("FAIL multi_valid: %0d valids at once, required at most 1", nv);
      end else if (nv == 1) begin
        exp_t e;
        int   own;
        logic [15:0] got;
        own = host_rvalid ? O_HOST : (fetch_valid ? O_FETCH : O_DATA);
        got = host_rvalid ? {8'h00, host_rdata} :
              (fetch_valid ? fetch_instr : {8'h00, data_rdata});
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: owner %0d data %h, required no response", own, got);
        end else begin
          e = sb.pop_front();
          if (own !== e.owner || got !== e.data) begin
            n_fail++;
            $display("FAIL rsp: owner %0d data %h, required owner %0d data %h",
                     own, got, e.owner, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int owner, input logic [15:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, mem_we1, mem_addr1, mem_wdata1} !== {1'b1, 1'b1, a, d}) begin
      n_fail++;
      $display("FAIL host_wr: gnt %b we %b addr %h wd %h, required 1 1 %h %h",
               host_gnt, mem_we1, mem_addr1, mem_wdata1, a, d);
    end
    step();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, mem_we1, mem_addr1} !== {1'b1, 1'b0, a}) begin
      n_fail++;
      $display("FAIL host_rd: gnt %b we %b addr %h, required 1 0 %h",
               host_gnt, mem_we1, mem_addr1, a);
    end
    push(O_HOST, {8'h00, d});
    step();
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    host_req = 1'b1; host_addr = 12'h123; fetch_req = 1'b1; fetch_addr = 12'h456;
    data_req = 1'b1; data_addr = 12'h789; pause_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({host_gnt, fetch_gnt, data_gnt, host_rvalid, fetch_valid, data_rvalid,
           pause_ack, mem_we1, mem_we2, mem_addr1, mem_addr2, mem_wdata1,
           mem_wdata2, host_rdata, data_rdata, fetch_instr} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: gnt %b%b%b valid %b%b%b ack %b addr1 %h addr2 %h, required all 0",
                 host_gnt, fetch_gnt, data_gnt, host_rvalid, fetch_valid,
                 data_rvalid, pause_ack, mem_addr1, mem_addr2);
      end
      step();
    end
    host_req = 1'b0; fetch_req = 1'b0; data_req = 1'b0; pause_req = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [AW-1:0] a2,
                          input logic [15:0] instr);
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, mem_addr1, mem_addr2, mem_we1, mem_we2} !== {1'b1, a, a2, 2'b00}) begin
      n_fail++;
      $display("FAIL fetch_gnt: gnt %b a1 %h a2 %h we %b%b, required 1 %h %h 00",
               fetch_gnt, mem_addr1, mem_addr2, mem_we1, mem_we2, a, a2);
    end
    push(O_FETCH, instr);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    host_write(12'h200, 8'h12);
    host_write(12'h201, 8'h34);
    do_fetch(12'h200, 12'h201, 16'h1234);
  endtask

  task automatic test_fetch_wrap();
    host_write(12'hFFF, 8'hAB);
    host_write(12'h000, 8'hCD);
    do_fetch(12'hFFF, 12'h000, 16'hABCD);
  endtask

  task automatic test_host_priority();
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h300; host_wdata = 8'h5A;
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h200;
    fetch_req = 1'b1; fetch_addr = 12'h200;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, data_gnt, fetch_gnt, mem_we1, mem_addr1} !== {4'b1001, 12'h300}) begin
      n_fail++;
      $display("FAIL host_prio: gnt h%b d%b f%b we %b addr %h, required h1 d0 f0 we 1 addr 300",
               host_gnt, data_gnt, fetch_gnt, mem_we1, mem_addr1);
    end
    step();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_gnt, fetch_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL after_host_data: gnt d%b f%b, required d1 f0", data_gnt, fetch_gnt);
    end
    push(O_DATA, 16'h0012);
    step();
    data_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_gnt, fetch_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_host_fetch: gnt d%b f%b, required d0 f1", data_gnt, fetch_gnt);
    end
    push(O_FETCH, 16'h1234);
    step();
    fetch_req = 1'b0;
    host_read(12'h300, 8'h5A);
    step();
  endtask

  task automatic test_back_to_back();
    bit exp_data = 1'b1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h201;
    fetch_req = 1'b1; fetch_addr = 12'h200;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({data_gnt, fetch_gnt} !== {exp_data, ~exp_data}) begin
        n_fail++;
        $display("FAIL rr[%0d]: gnt d%b f%b, required d%b f%b",
                 i, data_gnt, fetch_gnt, exp_data, ~exp_data);
      end
      if (exp_data) push(O_DATA, 16'h0034);
      else          push(O_FETCH, 16'h1234);
      exp_data = ~exp_data;
      step();
    end
    data_req = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_pause();
    fetch_req = 1'b1; fetch_addr = 12'h200; pause_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, pause_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL pause_n: gnt %b ack %b, required 1 0", fetch_gnt, pause_ack);
    end
    push(O_FETCH, 16'h1234);
    step();
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h201;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, data_gnt, pause_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL pause_drain: gnt f%b d%b ack %b, required 0 0 0",
               fetch_gnt, data_gnt, pause_ack);
    end
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h300;
    @(negedge clk);
    n_checks++;
    if ({pause_ack, host_gnt, fetch_gnt, data_gnt} !== 4'b1100) begin
      n_fail++;
      $display("FAIL paused_host: ack %b gnt h%b f%b d%b, required 1 1 0 0",
               pause_ack, host_gnt, fetch_gnt, data_gnt);
    end
    push(O_HOST, 16'h005A);
    step();
    host_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) pause_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({pause_ack, fetch_gnt, data_gnt} !== 3'b100) begin
        n_fail++;
        $display("FAIL paused_hold[%0d]: ack %b gnt f%b d%b, required 1 0 0",
                 i, pause_ack, fetch_gnt, data_gnt);
      end
      step();
    end
    @(negedge clk);
    n_checks++;
    if ({pause_ack, data_gnt, fetch_gnt} !== 3'b010) begin
      n_fail++;
      $display("FAIL resume_data: ack %b gnt d%b f%b, required 0 1 0",
               pause_ack, data_gnt, fetch_gnt);
    end
    push(O_DATA, 16'h0034);
    step();
    data_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fetch_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_fetch: gnt %b, required 1", fetch_gnt);
    end
    push(O_FETCH, 16'h1234);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_pause_drop();
    fetch_req = 1'b1; fetch_addr = 12'h200; pause_req = 1'b1;
    @(negedge clk);
    push(O_FETCH, 16'h1234);
    step();
    pause_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, pause_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL drain_drop: gnt %b ack %b, required 0 0", fetch_gnt, pause_ack);
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({fetch_gnt, pause_ack} !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_resume: gnt %b ack %b, required 1 0", fetch_gnt, pause_ack);
    end
    push(O_FETCH, 16'h1234);
    step();
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_pause_idle();
    bit exp_ack [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    pause_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) pause_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pause_ack !== exp_ack[i]) begin
        n_fail++;
        $display("FAIL pause_idle[%0d]: ack %b, required %b", i, pause_ack, exp_ack[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    data_req = 1'b1; data_we = 1'b0; data_addr = 12'h200;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: gnt %b, required 1", data_gnt);
    end
    step();
    reset = 1'b0; data_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({data_rvalid, data_rdata, data_gnt, mem_addr1} !== '0) begin
        n_fail++;
        $display("FAIL rst_mid_hold[%0d]: valid %b rdata %h gnt %b addr %h, required all 0",
                 i, data_rvalid, data_rdata, data_gnt, mem_addr1);
      end
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (data_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_after[%0d]: valid %b, required 0", i, data_rvalid);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    pause_req = 1'b0;
    step();
    test_reset();
    test_fetch();
    test_fetch_wrap();
    test_host_priority();
    test_back_to_back();
    test_pause();
    test_pause_drop();
    test_pause_idle();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Shares the Chip8 dual-port byte memory (`Chip8_memory`) among three requesters: host (ARM/Avalon side of `Chip8_Top`), CPU instruction fetch and CPU data access (sprite reads, Fx55/Fx65). It issues at most one transaction per cycle, routes read data back to the owner, and provides a pause/drain handshake so the host can stop the CPU cleanly before loading a ROM or fonts. It sits between `Chip8_Top`'s control logic and the memory instance.

## Interface
- `ADDR_W`, 12: memory byte address width (4 KiB).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `host_req`, `host_we`  in  1 each; `host_addr`  in  ADDR_W; `host_wdata`  in  8.
- `host_gnt`  out  1; `host_rvalid`  out  1; `host_rdata`  out  8.
- `fetch_req`  in  1; `fetch_addr`  in  ADDR_W (PC).
- `fetch_gnt`  out  1; `fetch_valid`  out  1; `fetch_instr`  out  16 ({mem[a], mem[a+1]}).
- `data_req`, `data_we`  in  1 each; `data_addr`  in  ADDR_W; `data_wdata`  in  8.
- `data_gnt`  out  1; `data_rvalid`  out  1; `data_rdata`  out  8.
- `pause_req`  in  1 (level, from host); `pause_ack`  out  1.
- `mem_addr1`, `mem_addr2`  out  ADDR_W; `mem_wdata1`, `mem_wdata2`  out  8; `mem_we1`, `mem_we2`  out  1.
- `mem_rdata1`, `mem_rdata2`  in  8 (registered, 1-cycle read latency).

## Operation
- Arbitration per cycle, combinational grant: host beats CPU requesters always.
- Between data and fetch: round-robin; `last_cpu` flag (reset = fetch) flips to the winner on each CPU grant; the one not served last wins a tie.
- CPU requests (fetch, data) are granted only in state RUN; host is granted in every state.
- Host/data transaction: port 1 only, `mem_addr1` = addr, `mem_we1` = we, `mem_wdata1` = wdata. Port 2 idle (`mem_we2` = 0).
- Fetch: port 1 = `fetch_addr`, port 2 = `fetch_addr + 1` modulo 2^ADDR_W (0xFFF → 0x000); both we = 0.
- `mem_we2` is never asserted; `mem_wdata2` = 0.
- Idle cycle: all mem outputs 0.
- Response tag register (owner, valid) captured on every granted read; writes produce no response.
- Cycle after a granted read: the tagged owner's `*_rvalid`/`fetch_valid` = 1 for exactly one cycle; `host_rdata`/`data_rdata` = `mem_rdata1`; `fetch_instr` = {`mem_rdata1`, `mem_rdata2`}. Non-owner data outputs are don't-care but held 0.
- FSM (enum `arb_state_t`): RUN → DRAIN when `pause_req` = 1; DRAIN → PAUSED when no CPU response is in flight (immediately if tag invalid); PAUSED → RUN when `pause_req` = 0. DRAIN → RUN if `pause_req` drops first.
- `pause_ack` = 1 only in PAUSED.

## Timing
- Reset: state RUN, `last_cpu` = fetch, tag invalid, all outputs 0.
- Grant latency 0 (same cycle as req when winning); read latency 1 (valid in cycle N+1 for grant in N).
- Requester holds req/addr until its gnt; a losing request is simply re-evaluated next cycle.
- Back-to-back grants allowed every cycle; responses pipeline one per cycle.
- `pause_req` rising in cycle N: no CPU grant from cycle N+1; if CPU read granted in N, DRAIN lasts through its response (N+1), `pause_ack` in N+2; otherwise `pause_ack` in N+1.
- Host and CPU requesting in the same cycle: host granted, CPU gnt = 0.
- Reset asserted mid-transaction: tag cleared, pending response dropped, no valid pulse after reset release.

## Structure
- `chip8_pkg`: `arb_state_t` {RUN, DRAIN, PAUSED}; `owner_t` {OWN_NONE, OWN_HOST, OWN_FETCH, OWN_DATA}; `CHIP8_MEM_ADDR_W` = 12.
- Single module; no sub-module needed (arbiter is a few lines of combinational priority plus the tag/FSM registers).

## Test plan
- Reset then `fetch_req`, `fetch_addr` = 0x200 with mem[0x200..0x201] = 0x12,0x34 → `fetch_gnt` same cycle, next cycle `fetch_valid` = 1, `fetch_instr` = 0x1234.
- Fetch at 0xFFF, mem[0xFFF] = 0xAB, mem[0x000] = 0xCD → `mem_addr2` = 0x000, `fetch_instr` = 0xABCD.
- Host write 0x5A to 0x300 while data and fetch requesting → only `host_gnt`; next cycle data then fetch alternate; host read of 0x300 returns 0x5A with `host_rvalid` one cycle after grant.
- Data and fetch both held high for 6 cycles → grants alternate fetch? No: data first (last_cpu = fetch after reset), then fetch, data, fetch, data, fetch.
- `pause_req` raised in the cycle a fetch read is granted → `fetch_valid` next cycle, `pause_ack` the cycle after; further CPU reqs get no grant; host read still granted; dropping `pause_req` → CPU grants resume next cycle.
- Assert `reset` low the cycle after a granted data read → no `data_rvalid` ever appears; all outputs 0 during reset.
